// File: rtl/miriscv_lsu.sv
// Load-store unit: 3 cycles per access against gnt=req/rvalid+1 memory; stalls core until DONE.
// Define MIRISCV_LSU_MISALIGN_EN to trap misaligned half/word accesses without a bus request.
module miriscv_lsu (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_misalign_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_we;
  logic [2:0]  r_size;
  logic [1:0]  r_lane;
  logic        r_misalign;
  logic        w_issue;
  logic        w_misalign;
  logic        w_is_byte;
  logic        w_is_half;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign w_is_byte = (lsu_size_i[1:0] == 2'b00);
  assign w_is_half = (lsu_size_i[1:0] == 2'b01);

`ifdef MIRISCV_LSU_MISALIGN_EN
  assign w_misalign = (w_is_half && lsu_addr_i[0]) ||
                      (!w_is_byte && !w_is_half && (lsu_addr_i[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    data_req_o  = 1'b0;
    w_issue     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (lsu_req_i) begin
          if (w_misalign) begin
            w_state_nxt = S_DONE;
          end else begin
            data_req_o  = 1'b1;
            w_issue     = 1'b1;
            w_state_nxt = data_gnt_i ? S_WAIT : S_REQ;
          end
        end
      end
      S_REQ: begin
        data_req_o = 1'b1;
        if (data_gnt_i) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (data_rvalid_i) w_state_nxt = S_DONE;
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (rst_i) begin
      data_req_o  = 1'b0;
      w_state_nxt = S_IDLE;
    end
  end

  assign lsu_stall_req_o = lsu_req_i && (r_state != S_DONE) && !rst_i;
  assign lsu_misalign_o  = r_misalign;
  assign data_we_o       = lsu_we_i;
  assign data_addr_o     = {lsu_addr_i[31:2], 2'b00};

  always_comb begin
    data_be_o    = 4'b1111;
    data_wdata_o = lsu_data_i;
    if (w_is_byte) begin
      data_be_o    = 4'b0001 << lsu_addr_i[1:0];
      data_wdata_o = {4{lsu_data_i[7:0]}};
    end else if (w_is_half) begin
      data_be_o    = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
      data_wdata_o = {2{lsu_data_i[15:0]}};
    end
  end

  // Lane selection uses attributes captured at issue, so a dropped lsu_req_i cannot corrupt the result.
  always_comb begin
    unique case (r_lane)
      2'd0:    w_byte = data_rdata_i[7:0];
      2'd1:    w_byte = data_rdata_i[15:8];
      2'd2:    w_byte = data_rdata_i[23:16];
      default: w_byte = data_rdata_i[31:24];
    endcase
    w_half = r_lane[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    unique case (r_size[1:0])
      2'b00:   w_load_data = {{24{!r_size[2] && w_byte[7]}}, w_byte};
      2'b01:   w_load_data = {{16{!r_size[2] && w_half[15]}}, w_half};
      default: w_load_data = data_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      lsu_data_o <= 32'h0;
      r_misalign <= 1'b0;
      r_we       <= 1'b0;
      r_size     <= 3'b000;
      r_lane     <= 2'b00;
    end else begin
      r_state    <= w_state_nxt;
      r_misalign <= (r_state == S_IDLE) && lsu_req_i && w_misalign;
      if (w_issue) begin
        r_we   <= lsu_we_i;
        r_size <= lsu_size_i;
        r_lane <= lsu_addr_i[1:0];
      end
      if ((r_state == S_WAIT) && data_rvalid_i && !r_we) begin
        lsu_data_o <= w_load_data;
      end
    end
  end

endmodule

// File: tb/tb_miriscv_lsu.sv
// Scoreboard bench for miriscv_lsu with a behavioural data memory of programmable gnt/rvalid latency.
module tb_miriscv_lsu;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_data_i;
  logic [31:0] lsu_data_o;
  logic        lsu_stall_req_o;
  logic        lsu_misalign_o;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;

  always #5 clk = ~clk;

  miriscv_lsu dut (
    .clk_i(clk), .rst_i(rst_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i), .lsu_data_o(lsu_data_o),
    .lsu_stall_req_o(lsu_stall_req_o), .lsu_misalign_o(lsu_misalign_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
  );

  // Memory responder
  logic [31:0] mem [0:63];
  logic [31:0] rd_q = 32'h0;
  int req_cnt   = 0;
  int rv_timer  = 0;
  int gnt_delay = 0;
  int rv_delay  = 1;

  assign data_gnt_i    = data_req_o && (req_cnt >= gnt_delay);
  assign data_rvalid_i = (rv_timer == 1);
  assign data_rdata_i  = rd_q;

  always @(posedge clk) begin
    if (data_req_o && data_gnt_i) begin
      req_cnt  <= 0;
      rv_timer <= rv_delay;
      if (data_we_o) begin
        for (int b = 0; b < 4; b++)
          if (data_be_o[b]) mem[data_addr_o[7:2]][8*b +: 8] <= data_wdata_o[8*b +: 8];
      end else begin
        rd_q <= mem[data_addr_o[7:2]];
      end
    end else begin
      req_cnt <= data_req_o ? req_cnt + 1 : 0;
      if (rv_timer > 0) rv_timer <= rv_timer - 1;
    end
  end

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
  } bus_t;
  typedef struct packed {
    logic [31:0] d;
    logic        mis;
  } rsp_t;

  bus_t bq[$];
  rsp_t rq[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: bus handshakes and completed accesses are popped against the scoreboard.
  always @(negedge clk) begin
    if (data_req_o && data_gnt_i) begin
      if (bq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL bus_unexpected: got addr %h expected no request", data_addr_o);
      end else begin
        bus_t e;
        e = bq.pop_front();
        chk("bus_addr", data_addr_o, e.addr);
        chk("bus_we", {31'h0, data_we_o}, {31'h0, e.we});
        chk("bus_be", {28'h0, data_be_o}, {28'h0, e.be});
        if (e.we) chk("bus_wdata", data_wdata_o, e.wd);
      end
    end
    if (!rst_i && lsu_req_i && !lsu_stall_req_o) begin
      if (rq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got data %h expected no completion", lsu_data_o);
      end else begin
        rsp_t r;
        r = rq.pop_front();
        chk("rsp_data", lsu_data_o, r.d);
        chk("rsp_misalign", {31'h0, lsu_misalign_o}, {31'h0, r.mis});
      end
    end
  end

  task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, input logic exp_bus, input logic [3:0] ebe,
                        input logic [31:0] ewd, input logic [31:0] erd, input logic emis,
                        input int estall, input int ereq, input string nm);
    int n, nst, nrq;
    bit done;
    if (exp_bus) bq.push_back('{addr: {addr[31:2], 2'b00}, we: we, be: ebe, wd: ewd});
    rq.push_back('{d: erd, mis: emis});
    @(posedge clk); #1;
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = sz; lsu_addr_i = addr; lsu_data_i = wd;
    n = 0; nst = 0; nrq = 0; done = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      if (data_req_o) nrq++;
      if (lsu_stall_req_o) nst++;
      else done = 1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got stall after %0d cycles expected completion", nm, n);
    end
    chk({nm, "_stall_cycles"}, nst, estall);
    chk({nm, "_req_cycles"}, nrq, ereq);
    @(posedge clk); #1;
    lsu_req_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'b010;
    lsu_addr_i = 32'h0; lsu_data_i = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_stall", {31'h0, lsu_stall_req_o}, 32'h0);
    chk("rst_req", {31'h0, data_req_o}, 32'h0);
    chk("rst_data", lsu_data_o, 32'h0);
    chk("rst_misalign", {31'h0, lsu_misalign_o}, 32'h0);
    @(posedge clk); #1;
    rst_i = 1'b0; lsu_req_i = 1'b0;

    access(1, 3'b010, 32'h10, 32'hDEADBEEF, 1, 4'hF, 32'hDEADBEEF, 32'h0, 0, 2, 1, "sw10");
    access(1, 3'b010, 32'h20, 32'h8081F0F7, 1, 4'hF, 32'h8081F0F7, 32'h0, 0, 2, 1, "sw20");
    access(1, 3'b010, 32'h24, 32'h0,        1, 4'hF, 32'h0,        32'h0, 0, 2, 1, "sw24");
    access(0, 3'b010, 32'h10, 32'h0, 1, 4'hF, 32'h0, 32'hDEADBEEF, 0, 2, 1, "lw10");
    access(0, 3'b000, 32'h23, 32'h0, 1, 4'h8, 32'h0, 32'hFFFFFF80, 0, 2, 1, "lb23");
    access(0, 3'b100, 32'h23, 32'h0, 1, 4'h8, 32'h0, 32'h00000080, 0, 2, 1, "lbu23");
    access(0, 3'b001, 32'h20, 32'h0, 1, 4'h3, 32'h0, 32'hFFFFF0F7, 0, 2, 1, "lh20");
    access(0, 3'b101, 32'h22, 32'h0, 1, 4'hC, 32'h0, 32'h00008081, 0, 2, 1, "lhu22");
    access(1, 3'b000, 32'h25, 32'h000000AB, 1, 4'h2, 32'hABABABAB, 32'h00008081, 0, 2, 1, "sb25");
    access(1, 3'b001, 32'h26, 32'h00001234, 1, 4'hC, 32'h12341234, 32'h00008081, 0, 2, 1, "sh26");
    access(0, 3'b010, 32'h24, 32'h0, 1, 4'hF, 32'h0, 32'h1234AB00, 0, 2, 1, "lw24");
    access(0, 3'b001, 32'h26, 32'h0, 1, 4'hC, 32'h0, 32'h00001234, 0, 2, 1, "lh26");
    access(0, 3'b000, 32'h25, 32'h0, 1, 4'h2, 32'h0, 32'hFFFFFFAB, 0, 2, 1, "lb25");

    gnt_delay = 3; rv_delay = 2;
    access(0, 3'b010, 32'h20, 32'h0, 1, 4'hF, 32'h0, 32'h8081F0F7, 0, 6, 4, "lw_slow");
    gnt_delay = 0; rv_delay = 1;

`ifdef MIRISCV_LSU_MISALIGN_EN
    access(0, 3'b010, 32'h13, 32'h0, 0, 4'hF, 32'h0, 32'h8081F0F7, 1, 1, 0, "lw13_mis");
`else
    access(0, 3'b010, 32'h13, 32'h0, 1, 4'hF, 32'h0, 32'hDEADBEEF, 0, 2, 1, "lw13");
`endif

    // Reset while the load waits for a slow response
    rv_delay = 3;
    bq.push_back('{addr: 32'h10, we: 1'b0, be: 4'hF, wd: 32'h0});
    @(posedge clk); #1;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'b010; lsu_addr_i = 32'h10;
    @(negedge clk);
    chk("mr_stall_idle", {31'h0, lsu_stall_req_o}, 32'h1);
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(negedge clk);
    chk("mr_stall_in_rst", {31'h0, lsu_stall_req_o}, 32'h0);
    chk("mr_req_in_rst", {31'h0, data_req_o}, 32'h0);
    @(posedge clk); #1;
    rst_i = 1'b0; lsu_req_i = 1'b0;
    @(negedge clk);
    chk("mr_data_cleared", lsu_data_o, 32'h0);
    repeat (2) @(negedge clk);
    chk("mr_late_rvalid_data", lsu_data_o, 32'h0);
    chk("mr_late_rvalid_req", {31'h0, data_req_o}, 32'h0);
    rv_delay = 1;

    access(0, 3'b101, 32'h22, 32'h0, 1, 4'hC, 32'h0, 32'h00008081, 0, 2, 1, "lhu22_post_rst");

    repeat (3) @(negedge clk);
    chk("bus_queue_drained", bq.size(), 32'h0);
    chk("rsp_queue_drained", rq.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/miriscv_lsu.md
Name: miriscv_lsu

Overview:
Load-store unit of the miriscv core. It is the initiator on the data memory interface whose responder is miriscv_ram.
- Takes a load/store command from the decoder/ALU stage and stalls the pipeline while the access is in flight.
- Drives req/we/be/addr/wdata and sequences through gnt and rvalid.
- Returns load data extracted from the addressed byte lanes, sign- or zero-extended.

Parameters:
None. Width is fixed at 32-bit RV32I.

Ports:
clk_i  input  1  core clock
rst_i  input  1  synchronous reset, active-high
lsu_req_i  input  1  core requests a memory access; held high, with other lsu_* inputs stable, while lsu_stall_req_o=1
lsu_we_i  input  1  1=store, 0=load
lsu_size_i  input  3  funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; 011/110/111 treated as word
lsu_addr_i  input  32  byte address
lsu_data_i  input  32  store data (rs2), valid bits in LSBs
lsu_data_o  output  32  extended load result
lsu_stall_req_o  output  1  pipeline stall request
lsu_misalign_o  output  1  misaligned-access flag (see Optional Feature)
data_req_o  output  1  bus request
data_we_o  output  1  bus write enable
data_be_o  output  4  bus byte enables
data_addr_o  output  32  bus address
data_wdata_o  output  32  bus write data, lane-replicated
data_gnt_i  input  1  request accepted
data_rvalid_i  input  1  response valid; asserted for loads and stores
data_rdata_i  input  32  read word

Behaviour:
FSM states: IDLE, REQ, WAIT, DONE.
- Reset state is IDLE. Reset values: lsu_data_o=0, lsu_misalign_o=0. While rst_i=1, data_req_o and lsu_stall_req_o are forced 0.
- IDLE: on lsu_req_i=1, assert data_req_o combinationally.
  - gnt=1 -> WAIT.
  - gnt=0 -> REQ.
- REQ: hold data_req_o=1 until gnt=1, then go to WAIT.
- WAIT: data_req_o=0. On rvalid=1:
  - if load, register formatted data into lsu_data_o;
  - go to DONE.
- DONE: single cycle, then IDLE unconditionally. The core consumes the result and advances in this cycle. lsu_req_i still being high here belongs to the completed instruction and is never re-issued.
- lsu_stall_req_o = lsu_req_i && state!=DONE.
  - Against miriscv_ram (gnt=req, rvalid +1 cycle), each access takes 3 cycles: stall high in cycles 0 and 1, low in cycle 2.
  - Back-to-back accesses incur one IDLE bubble.
- data_addr_o = lsu_addr_i with bits [1:0] forced 0. data_we_o = lsu_we_i. Both are combinational and are only meaningful while data_req_o=1.
- data_be_o:
  - byte: 4'b0001 << addr[1:0]
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
- data_wdata_o:
  - byte: {4{lsu_data_i[7:0]}}
  - half: {2{lsu_data_i[15:0]}}
  - word: lsu_data_i
- Load extraction:
  - byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- lsu_data_o holds its value until the next load completes. Stores leave it unchanged.
- rvalid while in IDLE or REQ: ignored. gnt outside IDLE/REQ: ignored.
- lsu_req_i dropping mid-transaction: the bus transaction still completes (REQ/WAIT -> DONE -> IDLE); load data is still captured.
- Reset mid-transaction: IDLE next cycle, outstanding response ignored, lsu_data_o=0.

Optional Feature:
Macro MIRISCV_LSU_MISALIGN_EN.
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, detected in IDLE with lsu_req_i=1, issues no bus request (data_req_o stays 0).
  - FSM goes directly to DONE with lsu_misalign_o=1 for that DONE cycle only.
  - Stall is high for 1 cycle; lsu_data_o is unchanged.
- Undefined:
  - lsu_misalign_o is tied 0.
  - Misaligned accesses proceed with low address bits ignored per the lane rules above (half uses addr[1]; word is aligned).

Test Plan:
1. SW addr=0x10 data=0xDEADBEEF, RAM model gnt=req -> be=1111, wdata=0xDEADBEEF, stall high 2 cycles then low 1; subsequent LW 0x10 returns 0xDEADBEEF.
2. Mem[0x20]=0x8081F0F7: LB 0x23 -> 0xFFFFFF80; LBU 0x23 -> 0x00000080; LH 0x20 -> 0xFFFFF0F7; LHU 0x22 -> 0x00008081.
3. SB 0x25 data=0x000000AB -> be=0010, wdata=0xABABABAB; SH 0x26 data=0x1234 -> be=1100, wdata=0x12341234.
4. gnt delayed 3 cycles, rvalid +2 after gnt -> data_req_o held 4 cycles, stall high 6 cycles, DONE exactly 1 cycle, no second request while lsu_req_i remains high in DONE.
5. rst_i asserted in WAIT -> next cycle IDLE, lsu_data_o=0, late rvalid ignored, stall 0 during reset.
6. With MIRISCV_LSU_MISALIGN_EN: LW 0x13 -> no data_req_o, lsu_misalign_o=1 one cycle, stall 1 cycle. Without the macro: LW 0x13 reads the word at 0x10.
